vgacon_text_sched: RTL and testbench
====================================

# vgacon_text_sched

Terminal-style scheduler for the VGA console's single-port text buffer (9-bit cells: `{color[1:0], ascii[6:0]}`). It converts an incoming character stream into buffer writes at a hardware cursor, and handles CR/LF/BS/FF and automatic scroll-up. It shares the one memory port with the video scan-out reader, which always has priority. It sits between the host register interface and the text RAM, replacing direct address-mapped host writes.

## Interface
- `NUM_ROWS`, 3, text rows
- `NUM_COLS`, 10, text columns
- `ADDR_W`, `$clog2(NUM_ROWS*NUM_COLS)`, buffer address width

Ports:
- `clk`  in  1  project clock
- `rst`  in  1  reset, synchronous, active-high
- `ch_valid`  in  1  stream character valid
- `ch_data`  in  9  `{color[1:0], ascii[6:0]}`
- `ch_ready`  out  1  block can accept a character
- `vid_req`  in  1  video reader needs the port this cycle
- `vid_addr`  in  ADDR_W  video read address
- `mem_en`  out  1  port enable
- `mem_we`  out  1  write enable
- `mem_addr`  out  ADDR_W  port address
- `mem_wdata`  out  9  write data
- `mem_rdata`  in  9  read data, one-cycle latency; video consumes it directly
- `cur_row`  out  `$clog2(NUM_ROWS)`  cursor row
- `cur_col`  out  `$clog2(NUM_COLS)`  cursor column
- `busy`  out  1  scroll or clear in progress
- `scrolled`  out  1  one-cycle pulse when a scroll completes

## Operation
- **Port arbitration.** `vid_req` = 1 drives `mem_en`=1, `mem_we`=0, `mem_addr`=`vid_addr` combinationally; the controller is stalled that cycle. Otherwise the controller owns the port.
- **States:**
  - CLEAR: write blank `9'h020` to each address, 0..NUM_CHARS-1.
  - IDLE
  - WRITE: one write at the cursor.
  - SCROLL_RD / SCROLL_WR: copy address i+NUM_COLS to i, for i = 0..(NUM_ROWS-1)*NUM_COLS-1.
  - SCROLL_BLANK: write blank to the last row.
- **Accept.** `ch_ready`=1 only in IDLE. A character is accepted on `ch_valid & ch_ready`. Decode uses `ch_data[6:0]`:
  - 0x20–0x7E → WRITE `ch_data`, then `col++`. If col reaches NUM_COLS, col=0 and advance row.
  - 0x0A (LF, implies CR) → col=0, advance row.
  - 0x0D → col=0. No memory access; stays IDLE.
  - 0x08 → col-- if col>0. No erase.
  - 0x0C → CLEAR, then cursor (0,0).
  - Other codes are consumed and ignored.
- **Advance row.** If row < NUM_ROWS-1, row++. Otherwise enter SCROLL_RD; the cursor stays on the last row, col=0.
- **Cursor address.** The cursor linear address is kept in a register updated incrementally with row/col; no multiplier.
- **Scroll read path.**
  - A read granted in cycle N has its `mem_rdata` captured unconditionally into a hold register in cycle N+1.
  - The corresponding write issues in the first granted cycle ≥ N+1.
  - A read not granted is retried.
- **Completion.** After the last SCROLL_BLANK write: `scrolled`=1 for one cycle, then return to IDLE.
- **busy.** `busy`=1 in CLEAR, SCROLL_*.

## Timing
- **Reset** (`rst` sampled high):
  - state ← CLEAR, cursor (0,0), `scrolled`=0, `ch_ready`=0, `busy`=1.
  - Controller `mem_en`/`mem_we`=0 during reset; `vid_req` is still honoured.
  - Reset mid-scroll or mid-write aborts immediately.
- **Post-reset clear:** NUM_CHARS granted cycles, then IDLE (`busy`=0, `ch_ready`=1).
- **Printable character,** accepted in cycle A:
  - Write occurs at A+1 if `vid_req`=0, else at the first later granted cycle.
  - Cursor updates in the write cycle; `ch_ready` returns the following cycle.
- **CR/BS:** `ch_ready` stays 1; the cursor updates at A+1.
- **Scroll, no video contention:** 2·(NUM_ROWS-1)·NUM_COLS + NUM_COLS cycles; 50 cycles for 3×10.
- **Writes and video:** a write never coincides with a video grant.
- **Last cell:** a printable character written at (last row, last col) triggers scroll directly after its write.

## Structure
- **Shared package `vgacon_pkg`:**
  - NUM_ROWS / NUM_COLS defaults
  - `CELL_BLANK = 9'h020`
  - control-code constants (0x08, 0x0A, 0x0C, 0x0D)
  - state enum
  - cell typedef `{color, ascii}`
- **Sub-module `vgacon_tbuf_arb`:** two-requester fixed-priority port mux (video > controller). It returns `grant` to the FSM.

## Test plan
- **Reset clear:** pulse `rst`, `vid_req`=0 → 30 blank writes to addresses 0..29; then `ch_ready`=1, cursor (0,0).
- **Write and wrap:** send 0x141 ('A', color 01) → `mem_we` at address 0 with data 0x141, then cursor (0,1). Send 10 printable characters → cursor wraps to (1,0).
- **Video contention:** hold `vid_req`=1 for 5 cycles after accept → no controller write during those cycles; the write lands in cycle 6, and `mem_addr` follows `vid_addr` throughout.
- **Scroll:** fill rows 0–2, then send LF at row 2 → buffer rows 0,1 = old rows 1,2; row 2 blank; `scrolled` pulses once; 50 cycles with no contention. Repeat with `vid_req` toggling every cycle → identical final contents.
- **Control codes:** BS at col 0 → cursor unchanged. CR at (1,7) → (1,0). FF → 30 blank writes, cursor (0,0).
- **Abort:** assert `rst` during scroll cycle 20 → CLEAR restarts; final buffer is all `0x020`.

Source files
------------

// File: rtl/vgacon_pkg.sv
// vgacon_pkg: shared constants, cell type and scheduler states for the VGA text console
package vgacon_pkg;
    localparam int DEF_ROWS = 3;
    localparam int DEF_COLS = 10;
    localparam logic [8:0] CELL_BLANK = 9'h020;
    localparam logic [6:0] CC_BS = 7'h08;
    localparam logic [6:0] CC_LF = 7'h0A;
    localparam logic [6:0] CC_FF = 7'h0C;
    localparam logic [6:0] CC_CR = 7'h0D;
    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE,
        S_SCROLL_RD,
        S_SCROLL_WR,
        S_SCROLL_BLANK
    } state_t;
    typedef struct packed {
        logic [1:0] color;
        logic [6:0] ascii;
    } cell_t;
    function automatic logic is_printable(input logic [6:0] a);
        return a >= 7'h20 && a <= 7'h7E;
    endfunction
endpackage

// File: rtl/vgacon_tbuf_arb.sv
// vgacon_tbuf_arb: fixed-priority text buffer port mux, video reader over controller
module vgacon_tbuf_arb #(
    parameter int ADDR_W = 5
) (
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              ctl_en,
    input  logic              ctl_we,
    input  logic [ADDR_W-1:0] ctl_addr,
    input  logic [8:0]        ctl_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [8:0]        mem_wdata,
    output logic              grant
);
    assign mem_en    = vid_req | ctl_en;
    assign mem_we    = ~vid_req & ctl_we;
    assign mem_addr  = vid_req ? vid_addr : ctl_addr;
    assign mem_wdata = ctl_wdata;
    assign grant     = ~vid_req & ctl_en;
endmodule

// File: rtl/vgacon_text_sched.sv
// vgacon_text_sched: turns a character stream into text buffer writes with cursor, control codes and scroll
module vgacon_text_sched
    import vgacon_pkg::*;
#(
    parameter int NUM_ROWS = DEF_ROWS,
    parameter int NUM_COLS = DEF_COLS,
    parameter int ADDR_W   = $clog2(NUM_ROWS*NUM_COLS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ch_valid,
    input  logic [8:0]                  ch_data,
    output logic                        ch_ready,
    input  logic                        vid_req,
    input  logic [ADDR_W-1:0]           vid_addr,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [8:0]                  mem_wdata,
    input  logic [8:0]                  mem_rdata,
    output logic [$clog2(NUM_ROWS)-1:0] cur_row,
    output logic [$clog2(NUM_COLS)-1:0] cur_col,
    output logic                        busy,
    output logic                        scrolled
);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_ROWS*NUM_COLS-1);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((NUM_ROWS-1)*NUM_COLS);
    localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'((NUM_ROWS-1)*NUM_COLS-1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(NUM_COLS);
    localparam logic [RW-1:0]     LAST_ROW  = RW'(NUM_ROWS-1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(NUM_COLS-1);

    state_t            state;
    cell_t             ch, wdata_q;
    logic [ADDR_W-1:0] cnt, cur_addr, ctl_addr;
    logic [8:0]        hold, ctl_wdata;
    logic              rd_fresh, grant, ctl_en, ctl_we, last_row, last_col;

    assign ch       = ch_data;
    assign ch_ready = state == S_IDLE;
    assign busy     = state inside {S_CLEAR, S_SCROLL_RD, S_SCROLL_WR, S_SCROLL_BLANK};
    assign last_row = cur_row == LAST_ROW;
    assign last_col = cur_col == LAST_COL;

    // cnt walks the destination address; scroll reads come from one row below
    always_comb begin
        ctl_en    = ~rst & (state != S_IDLE);
        ctl_we    = ctl_en & (state != S_SCROLL_RD);
        ctl_addr  = state == S_WRITE ? cur_addr : state == S_SCROLL_RD ? cnt + ROW_STEP : cnt;
        ctl_wdata = state == S_WRITE ? wdata_q : state == S_SCROLL_WR ? (rd_fresh ? mem_rdata : hold) : CELL_BLANK;
    end

    vgacon_tbuf_arb #(.ADDR_W(ADDR_W)) u_arb (
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .ctl_en   (ctl_en),
        .ctl_we   (ctl_we),
        .ctl_addr (ctl_addr),
        .ctl_wdata(ctl_wdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .grant    (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CLEAR;
            cnt      <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            cur_addr <= '0;
            scrolled <= 1'b0;
            rd_fresh <= 1'b0;
            hold     <= CELL_BLANK;
            wdata_q  <= CELL_BLANK;
        end else begin
            scrolled <= 1'b0;
            rd_fresh <= grant && state == S_SCROLL_RD;
            if (rd_fresh) hold <= mem_rdata;
            case (state)
                S_CLEAR: if (grant) begin
                    cnt <= cnt == ADDR_LAST ? '0 : cnt + 1'b1;
                    if (cnt == ADDR_LAST) begin
                        state    <= S_IDLE;
                        cur_row  <= '0;
                        cur_col  <= '0;
                        cur_addr <= '0;
                    end
                end
                S_IDLE: if (ch_valid) begin
                    if (is_printable(ch.ascii)) begin
                        wdata_q <= ch;
                        state   <= S_WRITE;
                    end else if (ch.ascii == CC_LF) begin
                        cur_col  <= '0;
                        cur_row  <= last_row ? cur_row : cur_row + 1'b1;
                        cur_addr <= last_row ? LAST_BASE : cur_addr - ADDR_W'(cur_col) + ROW_STEP;
                        state    <= last_row ? S_SCROLL_RD : S_IDLE;
                    end else if (ch.ascii == CC_CR) begin
                        cur_col  <= '0;
                        cur_addr <= cur_addr - ADDR_W'(cur_col);
                    end else if (ch.ascii == CC_BS && cur_col != '0) begin
                        cur_col  <= cur_col - 1'b1;
                        cur_addr <= cur_addr - 1'b1;
                    end else if (ch.ascii == CC_FF) begin
                        state <= S_CLEAR;
                    end
                end
                S_WRITE: if (grant) begin
                    cur_col  <= last_col ? '0 : cur_col + 1'b1;
                    cur_row  <= last_col && !last_row ? cur_row + 1'b1 : cur_row;
                    cur_addr <= last_col && last_row ? LAST_BASE : cur_addr + 1'b1;
                    state    <= last_col && last_row ? S_SCROLL_RD : S_IDLE;
                end
                S_SCROLL_RD: if (grant) state <= S_SCROLL_WR;
                S_SCROLL_WR: if (grant) begin
                    cnt   <= cnt + 1'b1;
                    state <= cnt == COPY_LAST ? S_SCROLL_BLANK : S_SCROLL_RD;
                end
                S_SCROLL_BLANK: if (grant) begin
                    cnt <= cnt == ADDR_LAST ? '0 : cnt + 1'b1;
                    if (cnt == ADDR_LAST) begin
                        state    <= S_IDLE;
                        scrolled <= 1'b1;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_vgacon_text_sched.sv
// tb_vgacon_text_sched: directed stimulus against a terminal-level screen model with per-cycle port checks
module tb_vgacon_text_sched;
    localparam int R = 3;
    localparam int C = 10;
    localparam int N = R*C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ch_valid = 1'b0;
    logic [8:0] ch_data = '0;
    logic       ch_ready;
    logic       vid_req;
    logic [4:0] vid_addr;
    logic       mem_en, mem_we;
    logic [4:0] mem_addr;
    logic [8:0] mem_wdata, mem_rdata, rdata;
    logic [1:0] cur_row;
    logic [3:0] cur_col;
    logic       busy, scrolled;

    logic [8:0] ram [N] = '{default: 9'h1FF};
    logic [8:0] scr [N];
    int wr_cnt = 0;
    int mrow, mcol, vid_mode, sc_cnt, checks, errors;

    always #5 clk = ~clk;

    vgacon_text_sched #(.NUM_ROWS(R), .NUM_COLS(C)) dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .vid_req(vid_req), .vid_addr(vid_addr), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .scrolled(scrolled)
    );

    assign mem_rdata = rdata;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end
            rdata <= ram[mem_addr];
        end
    end

    initial begin
        vid_req = 1'b0;
        vid_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            vid_req = vid_mode == 2 ? ~vid_req : (vid_mode == 1);
            vid_addr = 5'($urandom_range(0, N-1));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (vid_req) begin
            chk("arb_en", 32'(mem_en), 1);
            chk("arb_we", 32'(mem_we), 0);
            chk("arb_addr", 32'(mem_addr), 32'(vid_addr));
        end
        if (mem_we) chk("wr_range", 32'(mem_addr < N), 1);
        if (ch_ready) begin
            chk("cur_model", 32'({cur_row, cur_col}), 32'(mrow*16 + mcol));
            chk("ready_busy", 32'(busy), 0);
        end
        sc_cnt += int'(scrolled);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ch_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(ch_ready), 1);
    endtask

    task automatic model_adv();
        if (mrow < R-1) mrow++;
        else begin
            for (int i = 0; i < (R-1)*C; i++) scr[i] = scr[i+C];
            for (int i = (R-1)*C; i < N; i++) scr[i] = 9'h020;
        end
    endtask

    task automatic model_char(input logic [8:0] c);
        logic [6:0] a = c[6:0];
        if (a >= 7'h20 && a <= 7'h7E) begin
            scr[mrow*C + mcol] = c;
            mcol++;
            if (mcol == C) begin
                mcol = 0;
                model_adv();
            end
        end else if (a == 7'h0A) begin
            mcol = 0;
            model_adv();
        end else if (a == 7'h0D) mcol = 0;
        else if (a == 7'h08) begin
            if (mcol > 0) mcol--;
        end else if (a == 7'h0C) begin
            for (int i = 0; i < N; i++) scr[i] = 9'h020;
            mrow = 0;
            mcol = 0;
        end
    endtask

    task automatic send(input logic [8:0] c);
        wait_ready();
        ch_valid = 1'b1;
        ch_data = c;
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        model_char(c);
        tick();
    endtask

    task automatic check_screen(input string name);
        for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", name, i), 32'(ram[i]), 32'(scr[i]));
    endtask

    initial begin
        int n, w0, s0;
        for (int i = 0; i < N; i++) scr[i] = 9'h020;
        mrow = 0; mcol = 0; vid_mode = 0; sc_cnt = 0; checks = 0; errors = 0;
        repeat (2) tick();
        chk("rst_ready", 32'(ch_ready), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_cur", 32'({cur_row, cur_col}), 0);
        rst = 1'b0;
        w0 = wr_cnt;
        n = 0;
        while (ch_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("clear_cycles", n, 30);
        chk("clear_writes", wr_cnt - w0, 30);
        check_screen("clear");
        chk("clear_cur", 32'({cur_row, cur_col}), 0);

        send(9'h141);
        chk("a_we", 32'(mem_we), 1);
        chk("a_addr", 32'(mem_addr), 0);
        chk("a_data", 32'(mem_wdata), 32'h141);
        wait_ready();
        chk("a_cur", 32'({cur_row, cur_col}), 32'h01);
        for (int i = 0; i < 9; i++) send({2'b10, 7'(7'h42 + i)});
        wait_ready();
        chk("wrap_cur", 32'({cur_row, cur_col}), 32'h10);
        check_screen("row0");

        wait_ready();
        ch_valid = 1'b1;
        ch_data = 9'h05A;
        vid_mode = 1;
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        model_char(9'h05A);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("cont_nowr", 32'(mem_we), 0);
            if (k == 4) vid_mode = 0;
        end
        tick();
        chk("cont_we", 32'(mem_we), 1);
        chk("cont_addr", 32'(mem_addr), 10);
        chk("cont_data", 32'(mem_wdata), 32'h05A);

        for (int i = 0; i < 6; i++) send({2'b01, 7'(7'h61 + i)});
        wait_ready();
        chk("pre_cr_cur", 32'({cur_row, cur_col}), 32'h17);
        send(9'h00D);
        chk("cr_ready", 32'(ch_ready), 1);
        chk("cr_cur", 32'({cur_row, cur_col}), 32'h10);
        send(9'h008);
        chk("bs0_cur", 32'({cur_row, cur_col}), 32'h10);
        send(9'h078);
        send(9'h008);
        chk("bs_cur", 32'({cur_row, cur_col}), 32'h10);
        send(9'h001);
        check_screen("ctrl");

        for (int i = 0; i < 10; i++) send({2'b11, 7'(7'h30 + i)});
        for (int i = 0; i < 9; i++) send({2'b00, 7'(7'h50 + i)});
        wait_ready();
        chk("fill_cur", 32'({cur_row, cur_col}), 32'h29);
        s0 = sc_cnt;
        send(9'h00A);
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk("scroll_cycles", n, 50);
        chk("scroll_pulse", 32'(scrolled), 1);
        chk("scroll_count", sc_cnt - s0, 1);
        check_screen("scroll1");
        chk("scroll_cur", 32'({cur_row, cur_col}), 32'h20);
        chk("scroll_row0", 32'(ram[0]), 32'h1B0);
        chk("scroll_blank", 32'(ram[25]), 32'h020);
        tick();
        chk("scroll_pulse_end", 32'(scrolled), 0);

        vid_mode = 2;
        s0 = sc_cnt;
        for (int i = 0; i < 10; i++) send({2'b10, 7'(7'h61 + i)});
        wait_ready();
        vid_mode = 0;
        check_screen("lastcell");
        chk("lastcell_count", sc_cnt - s0, 1);
        chk("lastcell_cur", 32'({cur_row, cur_col}), 32'h20);
        chk("lastcell_row1", 32'(ram[10]), 32'h161);

        w0 = wr_cnt;
        send(9'h00C);
        chk("ff_busy", 32'(busy), 1);
        wait_ready();
        chk("ff_writes", wr_cnt - w0, 30);
        check_screen("ff");
        chk("ff_cur", 32'({cur_row, cur_col}), 0);

        send(9'h051); send(9'h052); send(9'h053);
        send(9'h00A); send(9'h00A); send(9'h054);
        send(9'h00A);
        repeat (19) tick();
        rst = 1'b1;
        #1;
        chk("abort_mem_en", 32'(mem_en), 0);
        for (int i = 0; i < N; i++) scr[i] = 9'h020;
        mrow = 0;
        mcol = 0;
        tick();
        rst = 1'b0;
        w0 = wr_cnt;
        wait_ready();
        chk("abort_writes", wr_cnt - w0, 30);
        check_screen("abort");
        chk("abort_cur", 32'({cur_row, cur_col}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
